// File: rtl/axi_pkg.sv
// Shared AXI definitions: FSM states, response and burst codes.
package axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_RESP,
    S_WR_DATA,
    S_WR_RESP
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] BURST_FIXED   = 2'b00;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] BURST_WRAP    = 2'b10;

  function automatic logic burst_steps(
    input logic [1:0] burst
  );
    return (burst == BURST_INCR) ||
           (burst == BURST_WRAP);
  endfunction

endpackage

// File: rtl/axi_sram_slave.sv
// AXI3 slave bridging one transaction at a time onto a
// single-port 32-bit SRAM with one cycle of read latency.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  state_t              state, next;
  logic [3:0]          id_q;
  logic [7:0]          len_q;
  logic [7:0]          cnt_q;
  logic [1:0]          burst_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                rr_q;
  logic                ar_sel;
  logic                aw_sel;
  logic                adv;

  logic unused;
  assign unused = ^{arsize, arlock, arcache, arprot,
                    awsize, awlock, awcache, awprot,
                    wid, araddr[31:ADDR_W+2],
                    araddr[1:0], awaddr[31:ADDR_W+2],
                    awaddr[1:0]};

  assign rid        = id_q;
  assign bid        = id_q;
  assign rdata      = sram_rdata;
  assign rresp      = AXI_RESP_OKAY;
  assign bresp      = AXI_RESP_OKAY;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata;

  always_comb begin
    next     = state;
    arready  = 1'b0;
    awready  = 1'b0;
    wready   = 1'b0;
    rvalid   = 1'b0;
    rlast    = 1'b0;
    bvalid   = 1'b0;
    sram_en  = 1'b0;
    sram_wen = 4'b0000;
    ar_sel   = 1'b0;
    aw_sel   = 1'b0;
    adv      = 1'b0;
    if (!rst) begin
      unique case (state)
        S_IDLE: begin
          // rr_q set means the write side wins the next tie
          if (arvalid && !(awvalid && rr_q)) begin
            ar_sel  = 1'b1;
            arready = 1'b1;
            next    = S_RD_REQ;
          end else if (awvalid) begin
            aw_sel  = 1'b1;
            awready = 1'b1;
            next    = S_WR_DATA;
          end
        end
        S_RD_REQ: begin
          sram_en = 1'b1;
          next    = S_RD_RESP;
        end
        S_RD_RESP: begin
          rvalid = 1'b1;
          rlast  = (cnt_q == len_q);
          if (rready) begin
            if (cnt_q == len_q) begin
              next = S_IDLE;
            end else begin
              adv  = 1'b1;
              next = S_RD_REQ;
            end
          end
        end
        S_WR_DATA: begin
          wready = 1'b1;
          if (wvalid) begin
            sram_en  = 1'b1;
            sram_wen = wstrb;
            adv      = 1'b1;
            if (wlast) next = S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          bvalid = 1'b1;
          if (bready) next = S_IDLE;
        end
        default: next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      rr_q    <= 1'b0;
    end else begin
      state <= next;
      if (ar_sel) begin
        id_q    <= arid;
        addr_q  <= araddr[ADDR_W+1:2];
        len_q   <= arlen;
        burst_q <= arburst;
        cnt_q   <= '0;
      end
      if (aw_sel) begin
        id_q    <= awid;
        addr_q  <= awaddr[ADDR_W+1:2];
        len_q   <= awlen;
        burst_q <= awburst;
        cnt_q   <= '0;
      end
      if (arvalid && awvalid && (ar_sel || aw_sel))
        rr_q <= ar_sel;
      if (adv) begin
        cnt_q <= cnt_q + 8'd1;
        if (burst_steps(burst_q))
          addr_q <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave against a word-array
// reference model and a behavioural SRAM.
module tb_axi_sram_slave;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    arid = '0;
  logic [31:0]   araddr = '0;
  logic [7:0]    arlen = '0;
  logic [2:0]    arsize = '0;
  logic [1:0]    arburst = '0;
  logic [1:0]    arlock = '0;
  logic [3:0]    arcache = '0;
  logic [2:0]    arprot = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [3:0]    rid;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [3:0]    awid = '0;
  logic [31:0]   awaddr = '0;
  logic [7:0]    awlen = '0;
  logic [2:0]    awsize = '0;
  logic [1:0]    awburst = '0;
  logic [1:0]    awlock = '0;
  logic [3:0]    awcache = '0;
  logic [2:0]    awprot = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [3:0]    wid = '0;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wlast = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [3:0]    bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic          sram_en;
  logic [3:0]    sram_wen;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem  [DEPTH];
  logic [31:0] refm [DEPTH];

  always #5 clk = ~clk;

  axi_sram_slave #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid),
    .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready),
    .sram_en(sram_en), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = 32'(i);
    if (i == 4) return 32'hDEADBEEF;
    return (v * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // behavioural SRAM, reloaded with a known pattern on reset
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else if (sram_en) begin
      if (sram_wen == 4'b0000) sram_rdata <= mem[sram_addr];
      else
        for (int b = 0; b < 4; b++)
          if (sram_wen[b])
            mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_reload();
    for (int i = 0; i < DEPTH; i++) refm[i] = init_word(i);
  endtask

  task automatic drive_addr(input bit is_wr, input logic [3:0] id,
                            input logic [31:0] a,
                            input logic [7:0] len,
                            input logic [1:0] burst);
    if (is_wr) begin
      awid = id; awaddr = a; awlen = len; awburst = burst;
      awsize = 3'($urandom); awlock = 2'($urandom);
      awcache = 4'($urandom); awprot = 3'($urandom);
      awvalid = 1'b1;
    end else begin
      arid = id; araddr = a; arlen = len; arburst = burst;
      arsize = 3'($urandom); arlock = 2'($urandom);
      arcache = 4'($urandom); arprot = 3'($urandom);
      arvalid = 1'b1;
    end
  endtask

  task automatic wait_accept(input bit is_wr);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (is_wr ? awready : arready) break;
      n++;
      if (n > 200) begin
        check(is_wr ? "aw_timeout" : "ar_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (is_wr) awvalid = 1'b0;
    else arvalid = 1'b0;
  endtask

  task automatic addr_hs(input bit is_wr, input logic [3:0] id,
                         input logic [31:0] a,
                         input logic [7:0] len,
                         input logic [1:0] burst);
    drive_addr(is_wr, id, a, len, burst);
    wait_accept(is_wr);
  endtask

  // rmode: 0 ready always, 1 toggles per valid cycle, 2 random
  task automatic read_beats(input logic [3:0] id,
                            input logic [31:0] a,
                            input logic [7:0] len,
                            input logic [1:0] burst,
                            input int rmode);
    int beat, n;
    bit tog;
    logic [AW-1:0] cur;
    beat = 0; n = 0; tog = 1'b0;
    cur = a[AW+1:2];
    while (beat <= int'(len) && n < 3000) begin
      rready = (rmode == 0) ? 1'b1 :
               (rmode == 1) ? tog : 1'($urandom);
      @(negedge clk);
      if (rvalid) begin
        check("rdata", rdata, refm[cur]);
        check("rid", 32'(rid), 32'(id));
        check("rlast", 32'(rlast), 32'(beat == int'(len)));
        check("rresp", 32'(rresp), 0);
        tog = ~tog;
        if (rready) begin
          beat++;
          if (burst != 2'b00) cur = cur + 1'b1;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    if (beat <= int'(len)) check("read_timeout", 0, 1);
    rready = 1'b0;
  endtask

  task automatic write_beats(input logic [31:0] a,
                             input logic [1:0] burst,
                             input logic [31:0] dq[$],
                             input logic [3:0] sq[$]);
    int beat, n;
    logic [AW-1:0] cur;
    beat = 0; n = 0;
    cur = a[AW+1:2];
    while (beat < dq.size() && n < 3000) begin
      wvalid = ($urandom_range(0, 3) != 0);
      wdata  = dq[beat];
      wstrb  = sq[beat];
      wlast  = (beat == dq.size() - 1);
      wid    = 4'($urandom);
      @(negedge clk);
      if (wvalid && wready) begin
        check("sram_en", 32'(sram_en), 1);
        check("sram_wen", 32'(sram_wen), 32'(sq[beat]));
        check("sram_addr", 32'(sram_addr), 32'(cur));
        for (int b = 0; b < 4; b++)
          if (sq[beat][b]) refm[cur][8*b +: 8] = dq[beat][8*b +: 8];
        beat++;
        if (burst != 2'b00) cur = cur + 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    if (beat < dq.size()) check("write_timeout", 0, 1);
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic b_resp(input logic [3:0] id);
    int n;
    n = 0;
    forever begin
      bready = 1'($urandom);
      @(negedge clk);
      if (bvalid) begin
        check("bid", 32'(bid), 32'(id));
        check("bresp", 32'(bresp), 0);
        if (bready) break;
      end
      n++;
      if (n > 200) begin
        check("b_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  initial begin
    logic [31:0] dq[$];
    logic [3:0]  sq[$];
    logic [31:0] a;
    logic [7:0]  l;
    logic [1:0]  bu;
    logic [3:0]  id;
    int          nb;
    int          n;

    ref_reload();
    arvalid = 1'b1;
    awvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 32'(arready), 0);
    check("rst_awready", 32'(awready), 0);
    check("rst_wready", 32'(wready), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_sram_en", 32'(sram_en), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    arvalid = 1'b0;
    awvalid = 1'b0;
    @(posedge clk); #1;

    addr_hs(0, 4'd1, 32'h10, 8'd0, 2'b01);
    read_beats(4'd1, 32'h10, 8'd0, 2'b01, 0);

    dq = '{32'h12345678}; sq = '{4'b0100};
    addr_hs(1, 4'd0, 32'h8, 8'd0, 2'b01);
    write_beats(32'h8, 2'b01, dq, sq);
    b_resp(4'd0);
    check("byte2_only", mem[2],
          (init_word(2) & 32'hFF00FFFF) | 32'h00340000);
    addr_hs(0, 4'd3, 32'h8, 8'd0, 2'b01);
    read_beats(4'd3, 32'h8, 8'd0, 2'b01, 0);

    addr_hs(0, 4'd2, 32'h0, 8'd3, 2'b01);
    read_beats(4'd2, 32'h0, 8'd3, 2'b01, 1);

    drive_addr(0, 4'd5, 32'h20, 8'd1, 2'b01);
    drive_addr(1, 4'd6, 32'h30, 8'd0, 2'b01);
    @(negedge clk);
    check("tie1_arready", 32'(arready), 1);
    check("tie1_awready", 32'(awready), 0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    read_beats(4'd5, 32'h20, 8'd1, 2'b01, 2);
    wait_accept(1);
    dq = '{32'hCAFEF00D}; sq = '{4'hF};
    write_beats(32'h30, 2'b01, dq, sq);
    b_resp(4'd6);

    drive_addr(0, 4'd7, 32'h30, 8'd0, 2'b01);
    drive_addr(1, 4'd8, 32'h34, 8'd0, 2'b01);
    @(negedge clk);
    check("tie2_awready", 32'(awready), 1);
    check("tie2_arready", 32'(arready), 0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    dq = '{32'h0BADC0DE}; sq = '{4'hF};
    write_beats(32'h34, 2'b01, dq, sq);
    b_resp(4'd8);
    wait_accept(0);
    read_beats(4'd7, 32'h30, 8'd0, 2'b01, 0);

    dq = '{32'hA, 32'hB, 32'hC}; sq = '{4'hF, 4'hF, 4'hF};
    addr_hs(1, 4'd9, 32'h40, 8'd2, 2'b00);
    write_beats(32'h40, 2'b00, dq, sq);
    b_resp(4'd9);
    check("fixed_word", mem[16], 32'hC);
    check("fixed_lo", mem[15], init_word(15));
    check("fixed_hi", mem[17], init_word(17));
    addr_hs(0, 4'd9, 32'h3C, 8'd2, 2'b01);
    read_beats(4'd9, 32'h3C, 8'd2, 2'b01, 2);

    a = 32'((DEPTH - 2) * 4);
    addr_hs(0, 4'd4, a, 8'd3, 2'b01);
    read_beats(4'd4, a, 8'd3, 2'b01, 2);

    dq = '{32'h11, 32'h22}; sq = '{4'hF, 4'h3};
    addr_hs(1, 4'd10, 32'h80, 8'd5, 2'b01);
    write_beats(32'h80, 2'b01, dq, sq);
    b_resp(4'd10);
    dq = '{32'h33, 32'h44, 32'h55}; sq = '{4'h1, 4'hF, 4'h8};
    addr_hs(1, 4'd11, 32'hA0, 8'd0, 2'b10);
    write_beats(32'hA0, 2'b10, dq, sq);
    b_resp(4'd11);
    addr_hs(0, 4'd12, 32'h80, 8'd10, 2'b01);
    read_beats(4'd12, 32'h80, 8'd10, 2'b01, 0);
    addr_hs(0, 4'd13, 32'hA0, 8'd2, 2'b10);
    read_beats(4'd13, 32'hA0, 8'd2, 2'b10, 0);

    addr_hs(0, 4'd14, 32'h0, 8'd3, 2'b01);
    n = 0;
    forever begin
      rready = 1'b0;
      @(negedge clk);
      if (rvalid) break;
      n++;
      if (n > 50) begin
        check("rst_burst_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive_addr(0, 4'd2, 32'h10, 8'd1, 2'b01);
    @(negedge clk);
    check("midrst_rvalid", 32'(rvalid), 0);
    check("midrst_arready", 32'(arready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    arvalid = 1'b0;
    ref_reload();
    repeat (3) begin
      rready = 1'b1;
      @(negedge clk);
      check("post_rst_rvalid", 32'(rvalid), 0);
      @(posedge clk); #1;
    end
    rready = 1'b0;
    addr_hs(0, 4'd2, 32'h10, 8'd1, 2'b01);
    read_beats(4'd2, 32'h10, 8'd1, 2'b01, 2);

    for (int t = 0; t < 40; t++) begin
      a  = $urandom;
      bu = 2'($urandom_range(0, 2));
      id = 4'($urandom);
      l  = ($urandom_range(0, 7) == 0) ?
           8'($urandom_range(8, 40)) : 8'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        addr_hs(0, id, a, l, bu);
        read_beats(id, a, l, bu, 2);
      end else begin
        nb = ($urandom_range(0, 3) == 0) ?
             $urandom_range(1, 4) : int'(l) + 1;
        dq = {};
        sq = {};
        for (int k = 0; k < nb; k++) begin
          dq.push_back($urandom);
          sq.push_back(4'($urandom));
        end
        addr_hs(1, id, a, l, bu);
        write_beats(a, bu, dq, sq);
        b_resp(id);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
